bus_sram_resp: RTL and testbench

Responder end of the CPU-side addr_ok/data_ok memory bus. It accepts one request at a time from the bus interface, services it from an internal byte-lane-writable SRAM after a programmable latency, and returns read data with a single-cycle data_ok pulse. It sits on the memory side of the bus as the on-chip instruction/data RAM target and as the simulation target for the bus interface.

---
 rtl/bus_sram_resp_pkg.sv | 29 ++
 rtl/bus_sram_ram.sv | 38 +++
 rtl/bus_sram_resp.sv | 127 ++++++++++++
 tb/tb_bus_sram_resp.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sram_resp_pkg.sv
// ============================================================================
// Module   : bus_sram_resp_pkg
// Brief    : Shared types and constants for the addr_ok/data_ok SRAM responder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_sram_resp_pkg;

    localparam int          REG_BUS_W    = 32;
    localparam int          RESP_LAT_MAX = 15;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        WRITE_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_RESP = 2'd2
    } resp_state_e;

    // Reads still carry a nonzero ben to mark the request, so lanes only
    // turn into write strobes when the request is a write.
    function automatic logic [3:0] lane_we(input logic wr, input logic [3:0] ben);
        return (wr == WRITE_ENABLE) ? ben : 4'b0000;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_sram_ram.sv
// ============================================================================
// Module   : bus_sram_ram
// Brief    : Single-port 2^ADDR_WIDTH x 32 RAM, byte-lane writes, registered read
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_sram_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [0:(1 << ADDR_WIDTH)-1];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset; read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/bus_sram_resp.sv
// ============================================================================
// Module   : bus_sram_resp
// Brief    : addr_ok/data_ok bus responder backed by an on-chip SRAM
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_sram_resp
    import bus_sram_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_BUS_W-1:0] addr,
    input  logic [REG_BUS_W-1:0] din,
    input  logic                 wr,
    input  logic [3:0]           ben,
    output logic                 addr_ok,
    output logic                 data_ok,
    output logic [REG_BUS_W-1:0] dout,
    output logic                 proto_err
);

    localparam int              CNT_W      = $clog2(RESP_LAT_MAX + 1);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    resp_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic                 addr_ok_q, addr_ok_d;
    logic                 data_ok_q, data_ok_d;
    logic                 proto_err_q, proto_err_d;

    logic                 w_req;
    logic                 w_accept;
    logic [31:0]          w_rdata;
    logic                 unused_addr_bits;

    assign w_req    = |ben;
    assign w_accept = w_req & addr_ok_q;

    // Word-aligned and modulo memory size: the dropped bits alias freely.
    assign unused_addr_bits = ^{addr[REG_BUS_W-1:ADDR_WIDTH+2], addr[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_ok_d   = addr_ok_q;
        data_ok_d   = 1'b0;
        proto_err_d = proto_err_q | (w_req & ~addr_ok_q);
        unique case (state_q)
            RESP_IDLE: begin
                addr_ok_d = 1'b1;
                if (w_accept) begin
                    wr_d      = wr;
                    addr_ok_d = 1'b0;
                    if (LATENCY <= 1) begin
                        state_d   = RESP_RESP;
                        data_ok_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        state_d = RESP_WAIT;
                        cnt_d   = c_cnt_init;
                    end
                end
            end
            RESP_WAIT: begin
                cnt_d = cnt_q - c_cnt_one;
                if (cnt_q == c_cnt_one) begin
                    state_d   = RESP_RESP;
                    data_ok_d = 1'b1;
                end
            end
            RESP_RESP: begin
                state_d   = RESP_IDLE;
                addr_ok_d = 1'b1;
            end
            default: begin
                state_d   = RESP_IDLE;
                addr_ok_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RESP_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_ok_q   <= 1'b0;
            data_ok_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_ok_q   <= addr_ok_d;
            data_ok_q   <= data_ok_d;
            proto_err_q <= proto_err_d;
        end
    end

    // The RAM is only enabled at capture, so its read register holds the
    // word until the response goes out, whatever the latency.
    bus_sram_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (w_accept),
        .we    (lane_we(wr, ben)),
        .addr  (addr[ADDR_WIDTH+1:2]),
        .wdata (din),
        .rdata (w_rdata)
    );

    assign addr_ok   = addr_ok_q;
    assign data_ok   = data_ok_q;
    assign dout      = (data_ok_q && (wr_q != WRITE_ENABLE)) ? w_rdata : ZERO_WORD;
    assign proto_err = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_sram_resp.sv
// ============================================================================
// Module   : tb_bus_sram_resp
// Brief    : Directed bench for bus_sram_resp at LATENCY 1 and LATENCY 4
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bus_sram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a1 = '0, d1 = '0, a4 = '0, d4 = '0;
    logic        w1 = 1'b0, w4 = 1'b0;
    logic [3:0]  b1 = '0, b4 = '0;
    logic        ao1, dk1, pe1, ao4, dk4, pe4;
    logic [31:0] q1, q4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bus_sram_resp #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .addr(a1), .din(d1), .wr(w1), .ben(b1),
        .addr_ok(ao1), .data_ok(dk1), .dout(q1), .proto_err(pe1)
    );

    bus_sram_resp #(.ADDR_WIDTH(10), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .addr(a4), .din(d4), .wr(w4), .ben(b4),
        .addr_ok(ao4), .data_ok(dk4), .dout(q4), .proto_err(pe4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            checks++;
            if ({ao1, dk1, q1, pe1} !== 35'h0) begin
                errors++;
                $display("FAIL reset_dut1 addr_ok=%b data_ok=%b dout=%h proto_err=%b required all 0", ao1, dk1, q1, pe1);
            end
            checks++;
            if ({ao4, dk4, q4, pe4} !== 35'h0) begin
                errors++;
                $display("FAIL reset_dut4 addr_ok=%b data_ok=%b dout=%h proto_err=%b required all 0", ao4, dk4, q4, pe4);
            end
        end
        cyc(); rst = 1'b1; smp();
        checks++;
        if ({ao1, ao4} !== 2'b00) begin
            errors++;
            $display("FAIL release_before_edge addr_ok=%b%b required 00", ao1, ao4);
        end
        cyc(); smp();
        checks++;
        if ({ao1, ao4, dk1, dk4} !== 4'b1100) begin
            errors++;
            $display("FAIL release_first_edge addr_ok/data_ok=%b required 1100", {ao1, ao4, dk1, dk4});
        end
    endtask

    task automatic test_write_read();
        cyc(); w1 = 1'b1; a1 = 32'h10; d1 = 32'hDEADBEEF; b1 = 4'hF; smp();
        checks++;
        if ({ao1, dk1} !== 2'b10) begin
            errors++;
            $display("FAIL wr_capture addr_ok/data_ok=%b required 10", {ao1, dk1});
        end
        cyc(); b1 = 4'h0; smp();
        checks++;
        if ({ao1, dk1} !== 2'b01 || q1 !== 32'h0) begin
            errors++;
            $display("FAIL wr_resp addr_ok/data_ok=%b dout=%h required 01 00000000", {ao1, dk1}, q1);
        end
        cyc(); w1 = 1'b0; a1 = 32'h10; b1 = 4'hF; smp();
        checks++;
        if ({ao1, dk1} !== 2'b10 || q1 !== 32'h0) begin
            errors++;
            $display("FAIL rd_capture addr_ok/data_ok=%b dout=%h required 10 00000000", {ao1, dk1}, q1);
        end
        cyc(); b1 = 4'h0; smp();
        checks++;
        if (dk1 !== 1'b1 || q1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_resp data_ok=%b dout=%h required 1 deadbeef", dk1, q1);
        end
        cyc(); smp();
        checks++;
        if ({ao1, dk1} !== 2'b10 || q1 !== 32'h0) begin
            errors++;
            $display("FAIL rd_after addr_ok/data_ok=%b dout=%h required 10 00000000", {ao1, dk1}, q1);
        end
    endtask

    // Each row is one request on the LATENCY-1 port followed by its RESP cycle.
    task automatic run_table1(input string name, input int n, input logic [3:0] tw,
                              input logic [31:0] ta [4], input logic [31:0] td [4],
                              input logic [3:0] tb [4], input logic [31:0] te [4]);
        for (int i = 0; i < n; i++) begin
            cyc(); w1 = tw[i]; a1 = ta[i]; d1 = td[i]; b1 = tb[i];
            cyc(); b1 = 4'h0; smp();
            checks++;
            if (dk1 !== 1'b1 || q1 !== te[i]) begin
                errors++;
                $display("FAIL %s[%0d] data_ok=%b dout=%h required 1 %h", name, i, dk1, q1, te[i]);
            end
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] ta [4] = '{32'h20, 32'h20, 32'h20, 32'h20};
        logic [31:0] td [4] = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'h0};
        logic [3:0]  tb [4] = '{4'hF, 4'b0101, 4'hF, 4'b0001};
        logic [31:0] te [4] = '{32'h0, 32'h0, 32'h11BB33DD, 32'h11BB33DD};
        run_table1("byte_lanes", 4, 4'b0011, ta, td, tb, te);
    endtask

    task automatic test_alias();
        logic [31:0] ta [4] = '{32'h00001004, 32'h00000004, 32'h00002007, 32'h0};
        logic [31:0] td [4] = '{32'h5A5AA5A5, 32'h0, 32'h0, 32'h0};
        logic [3:0]  tb [4] = '{4'hF, 4'hF, 4'hF, 4'h0};
        logic [31:0] te [4] = '{32'h0, 32'h5A5AA5A5, 32'h5A5AA5A5, 32'h0};
        run_table1("alias", 3, 4'b0001, ta, td, tb, te);
    endtask

    task automatic test_latency();
        logic exp_ok;
        cyc(); w4 = 1'b1; a4 = 32'h40; d4 = 32'hCAFEF00D; b4 = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            cyc(); b4 = 4'h0; smp();
            exp_ok = (i == 4);
            checks++;
            if (dk4 !== exp_ok || q4 !== 32'h0) begin
                errors++;
                $display("FAIL lat4_wr[T+%0d] data_ok=%b dout=%h required %b 00000000", i, dk4, q4, exp_ok);
            end
        end
        cyc(); w4 = 1'b0; a4 = 32'h40; b4 = 4'hF; smp();
        checks++;
        if (ao4 !== 1'b1) begin
            errors++;
            $display("FAIL lat4_rd_capture addr_ok=%b required 1", ao4);
        end
        for (int i = 1; i <= 4; i++) begin
            cyc(); b4 = 4'h0; smp();
            exp_ok = (i == 4);
            checks++;
            if (ao4 !== 1'b0 || dk4 !== exp_ok || q4 !== (exp_ok ? 32'hCAFEF00D : 32'h0)) begin
                errors++;
                $display("FAIL lat4_rd[T+%0d] addr_ok=%b data_ok=%b dout=%h required 0 %b", i, ao4, dk4, q4, exp_ok);
            end
        end
        cyc(); w4 = 1'b1; a4 = 32'h44; d4 = 32'h12345678; b4 = 4'hF; smp();
        checks++;
        if ({ao4, dk4} !== 2'b10) begin
            errors++;
            $display("FAIL lat4_b2b[T+5] addr_ok/data_ok=%b required 10", {ao4, dk4});
        end
        for (int i = 1; i <= 4; i++) begin
            cyc(); b4 = 4'h0; smp();
        end
        checks++;
        if (dk4 !== 1'b1 || q4 !== 32'h0) begin
            errors++;
            $display("FAIL lat4_b2b_resp data_ok=%b dout=%h required 1 00000000", dk4, q4);
        end
    endtask

    task automatic test_proto_err();
        cyc(); w4 = 1'b0; a4 = 32'h40; b4 = 4'hF;
        cyc(); b4 = 4'h0; smp();
        checks++;
        if (pe4 !== 1'b0) begin
            errors++;
            $display("FAIL perr_before proto_err=%b required 0", pe4);
        end
        cyc(); w4 = 1'b1; d4 = 32'h0; b4 = 4'hF;
        cyc(); w4 = 1'b0; b4 = 4'h0; smp();
        checks++;
        if (pe4 !== 1'b1) begin
            errors++;
            $display("FAIL perr_set proto_err=%b required 1", pe4);
        end
        cyc(); smp();
        checks++;
        if (dk4 !== 1'b1 || q4 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL perr_inflight data_ok=%b dout=%h required 1 cafef00d", dk4, q4);
        end
        cyc(); w4 = 1'b0; a4 = 32'h40; b4 = 4'hF; smp();
        checks++;
        if ({ao4, pe4} !== 2'b11) begin
            errors++;
            $display("FAIL perr_sticky addr_ok/proto_err=%b required 11", {ao4, pe4});
        end
        for (int i = 1; i <= 4; i++) begin
            cyc(); b4 = 4'h0; smp();
        end
        checks++;
        if (dk4 !== 1'b1 || q4 !== 32'hCAFEF00D || pe1 !== 1'b0) begin
            errors++;
            $display("FAIL perr_stray data_ok=%b dout=%h other_perr=%b required 1 cafef00d 0", dk4, q4, pe1);
        end
    endtask

    task automatic test_resp_collision();
        cyc(); w1 = 1'b0; a1 = 32'h20; b1 = 4'hF;
        cyc(); w1 = 1'b1; d1 = 32'h0; b1 = 4'hF; smp();
        checks++;
        if (dk1 !== 1'b1 || q1 !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL coll_resp data_ok=%b dout=%h required 1 11bb33dd", dk1, q1);
        end
        cyc(); w1 = 1'b0; b1 = 4'h0; smp();
        checks++;
        if ({ao1, pe1} !== 2'b11) begin
            errors++;
            $display("FAIL coll_perr addr_ok/proto_err=%b required 11", {ao1, pe1});
        end
        cyc(); a1 = 32'h20; b1 = 4'hF;
        cyc(); b1 = 4'h0; smp();
        checks++;
        if (dk1 !== 1'b1 || q1 !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL coll_ignored data_ok=%b dout=%h required 1 11bb33dd", dk1, q1);
        end
    endtask

    task automatic test_reset_mid();
        cyc(); w4 = 1'b1; a4 = 32'h48; d4 = 32'h600DCAFE; b4 = 4'hF;
        cyc(); b4 = 4'h0; w4 = 1'b0;
        cyc(); rst = 1'b0; smp();
        checks++;
        if ({ao4, dk4, pe4, pe1} !== 4'b0000 || q4 !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async addr_ok/data_ok/perr4/perr1=%b dout=%h required 0000 00000000", {ao4, dk4, pe4, pe1}, q4);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            checks++;
            if (dk4 !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_hold[%0d] data_ok=%b required 0", i, dk4);
            end
        end
        cyc(); rst = 1'b1; smp();
        checks++;
        if (ao4 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release addr_ok=%b required 0", ao4);
        end
        cyc(); smp();
        checks++;
        if ({ao4, dk4} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_first_edge addr_ok/data_ok=%b required 10", {ao4, dk4});
        end
        cyc(); w4 = 1'b0; a4 = 32'h48; b4 = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            cyc(); b4 = 4'h0; smp();
        end
        checks++;
        if (dk4 !== 1'b1 || q4 !== 32'h600DCAFE) begin
            errors++;
            $display("FAIL rstmid_committed data_ok=%b dout=%h required 1 600dcafe", dk4, q4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_alias();
        test_latency();
        test_proto_err();
        test_resp_collision();
        test_reset_mid();
        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
